// File: rtl/stack_engine.sv
// PUSH/POP rr sequencer for the LR35902 core: owns SP and moves a register pair over a byte bus.
// Optional build macro STACK_GUARD_EN enables start-time stack bounds checking with a fault pulse.
module stack_engine #(
    parameter logic [15:0] SP_RESET  = 16'hFFFE,
    parameter logic [15:0] GUARD_LO  = 16'hC000,
    parameter int          REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_pop,
    input  logic                 is_af,
    input  logic [REG_IDX_W-1:0] pair_idx,
    input  logic [15:0]          push_data,
    input  logic                 sp_load,
    input  logic [15:0]          sp_load_val,
    output logic [15:0]          sp,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [15:0]          mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ready,
    output logic [1:0]           wr_en,
    output logic [REG_IDX_W-1:0] wr_reg,
    output logic [15:0]          wr_data,
    output logic                 flag_we,
    output logic [7:0]           flag_data
);

`ifdef STACK_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        POP_LO,
        POP_HI,
        FIN
    } state_t;

    state_t                 state, state_next;
    logic [15:0]            sp_r;
    logic                   pop_q;
    logic                   af_q;
    logic [REG_IDX_W-1:0]   idx_q;
    logic [7:0]             hi_q;
    logic [7:0]             lo_q;

    logic [15:0]            sp_m1;
    logic [15:0]            sp_p1;
    logic [15:0]            sp_m2;
    logic                   guard_hit;
    logic                   start_ok;

    assign sp_m1 = sp_r - 16'd1;
    assign sp_p1 = sp_r + 16'd1;
    assign sp_m2 = sp_r - 16'd2;

    // Bounds are evaluated against the current SP, before the op is accepted.
    assign guard_hit = GUARD_ON && (op_pop ? (sp_r > 16'hFFFD) : (sp_m2 < GUARD_LO));
    assign start_ok  = (state == IDLE) && start && !sp_load && !guard_hit;
    assign fault     = (state == IDLE) && start && !sp_load && guard_hit;
    assign sp        = sp_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r  <= SP_RESET;
            pop_q <= 1'b0;
            af_q  <= 1'b0;
            idx_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sp_load) begin
                        sp_r <= sp_load_val;
                    end else if (start_ok) begin
                        pop_q <= op_pop;
                        af_q  <= is_af;
                        idx_q <= pair_idx;
                        hi_q  <= push_data[15:8];
                        lo_q  <= push_data[7:0];
                    end
                end
                PUSH_HI, PUSH_LO: begin
                    if (mem_ready) sp_r <= sp_m1;
                end
                POP_LO: begin
                    if (mem_ready) begin
                        lo_q <= mem_rdata;
                        sp_r <= sp_p1;
                    end
                end
                POP_HI: begin
                    if (mem_ready) begin
                        hi_q <= mem_rdata;
                        sp_r <= sp_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok) state_next = op_pop ? POP_LO : PUSH_HI;
            PUSH_HI: if (mem_ready) state_next = PUSH_LO;
            PUSH_LO: if (mem_ready) state_next = FIN;
            POP_LO:  if (mem_ready) state_next = POP_HI;
            POP_HI:  if (mem_ready) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_en     = 2'd0;
        wr_reg    = '0;
        wr_data   = '0;
        flag_we   = 1'b0;
        flag_data = '0;
        unique case (state)
            PUSH_HI: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_m1;
                mem_wdata = hi_q;
            end
            PUSH_LO: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_m1;
                mem_wdata = lo_q;
            end
            POP_LO, POP_HI: begin
                mem_req  = 1'b1;
                mem_addr = sp_r;
            end
            FIN: begin
                done = 1'b1;
                if (pop_q) begin
                    wr_reg = idx_q;
                    if (af_q) begin
                        wr_en     = 2'd1;
                        wr_data   = {8'h00, hi_q};
                        flag_we   = 1'b1;
                        flag_data = {lo_q[7:4], 4'h0};
                    end else begin
                        wr_en   = 2'd2;
                        wr_data = {hi_q, lo_q};
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: bus responder with programmable wait states and a byte-array stack model.
// Define STACK_GUARD_EN for both bench and RTL to exercise the guarded build.
module tb_stack_engine;

`ifdef STACK_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_pop;
    logic        is_af;
    logic [3:0]  pair_idx;
    logic [15:0] push_data;
    logic        sp_load;
    logic [15:0] sp_load_val;
    logic [15:0] sp;
    logic        busy;
    logic        done;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [1:0]  wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        flag_we;
    logic [7:0]  flag_data;

    int total = 0;
    int bad   = 0;

    logic [15:0] model_sp;
    logic [7:0]  tbmem [0:65535];

    always #5 clk = ~clk;

    stack_engine #(
        .SP_RESET (16'hFFFE),
        .GUARD_LO (16'hC000),
        .REG_IDX_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_pop     (op_pop),
        .is_af      (is_af),
        .pair_idx   (pair_idx),
        .push_data  (push_data),
        .sp_load    (sp_load),
        .sp_load_val(sp_load_val),
        .sp         (sp),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .flag_we    (flag_we),
        .flag_data  (flag_data)
    );

    function automatic bit reject(input bit pop, input logic [15:0] s);
        logic [15:0] below;
        below = s - 16'd2;
        return GUARD_ON && (pop ? (s > 16'hFFFD) : (below < 16'hC000));
    endfunction

    // One full PUSH/POP: start strobe, bus responder, writeback and SP checks against the model.
    task automatic do_op(input bit pop, input bit af, input logic [3:0] idx,
                         input logic [15:0] data, input int waits);
        logic [15:0] sp0;
        logic [15:0] exp_addr [2];
        logic [7:0]  exp_wd [2];
        logic [7:0]  lo_b;
        logic [7:0]  hi_b;
        logic [1:0]  exp_en;
        logic [15:0] exp_data;
        bit          rej;
        int          xfer;
        int          cnt;
        int          done_k;
        sp0 = model_sp;
        rej = reject(pop, sp0);
        lo_b = 8'h00;
        hi_b = 8'h00;
        if (pop) begin
            exp_addr[0] = sp0;
            exp_addr[1] = sp0 + 16'd1;
            lo_b = tbmem[exp_addr[0]];
            hi_b = tbmem[exp_addr[1]];
        end else begin
            exp_addr[0] = sp0 - 16'd1;
            exp_addr[1] = sp0 - 16'd2;
        end
        exp_wd[0] = data[15:8];
        exp_wd[1] = data[7:0];
        exp_en    = pop ? (af ? 2'd1 : 2'd2) : 2'd0;
        exp_data  = af ? {8'h00, hi_b} : {hi_b, lo_b};

        start = 1'b1; op_pop = pop; is_af = af; pair_idx = idx; push_data = data;
        @(negedge clk);
        total++;
        if (fault !== rej) begin
            bad++; $display("FAIL fault_at_start got=%b want=%b sp=%h", fault, rej, sp0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        op_pop = 1'($urandom); is_af = 1'($urandom); pair_idx = 4'($urandom); push_data = 16'($urandom);

        if (rej) begin
            total++;
            if (busy !== 1'b0 || mem_req !== 1'b0 || sp !== sp0) begin
                bad++; $display("FAIL reject_idle busy=%b req=%b sp=%h want busy=0 req=0 sp=%h",
                                busy, mem_req, sp, sp0);
            end
            return;
        end

        xfer = 0; cnt = 0; done_k = 0;
        for (int k = 1; k <= 200; k++) begin
            mem_ready = 1'b0;
            if (mem_req === 1'b1) begin
                total++;
                if (xfer >= 2) begin
                    bad++; $display("FAIL extra_xfer addr=%h want none", mem_addr);
                end else begin
                    if (mem_addr !== exp_addr[xfer] || mem_we !== !pop) begin
                        bad++; $display("FAIL bus_addr xfer=%0d got=%h we=%b want=%h we=%b",
                                        xfer, mem_addr, mem_we, exp_addr[xfer], !pop);
                    end
                    if (!pop) begin
                        total++;
                        if (mem_wdata !== exp_wd[xfer]) begin
                            bad++; $display("FAIL bus_wdata xfer=%0d got=%h want=%h",
                                            xfer, mem_wdata, exp_wd[xfer]);
                        end
                    end
                    if (cnt == waits) begin
                        mem_ready = 1'b1;
                        if (pop) mem_rdata = tbmem[exp_addr[xfer]];
                        else     tbmem[exp_addr[xfer]] = mem_wdata;
                        xfer++;
                        cnt = 0;
                    end else begin
                        mem_rdata = 8'($urandom);
                        cnt++;
                    end
                end
            end
            total++;
            if (done === 1'b1) begin
                done_k = k;
                if (wr_en !== exp_en || flag_we !== (pop && af)) begin
                    bad++; $display("FAIL wb_strobes wr_en=%0d flag_we=%b want wr_en=%0d flag_we=%b",
                                    wr_en, flag_we, exp_en, pop && af);
                end
                if (pop) begin
                    total++;
                    if (wr_reg !== idx || wr_data !== exp_data) begin
                        bad++; $display("FAIL wb_data reg=%0d data=%h want reg=%0d data=%h",
                                        wr_reg, wr_data, idx, exp_data);
                    end
                    if (af) begin
                        total++;
                        if (flag_data !== {lo_b[7:4], 4'h0}) begin
                            bad++; $display("FAIL flag_data got=%h want=%h",
                                            flag_data, {lo_b[7:4], 4'h0});
                        end
                    end
                end
            end else if (wr_en !== 2'd0 || flag_we !== 1'b0) begin
                bad++; $display("FAIL stray_wb cycle=%0d wr_en=%0d flag_we=%b want 0", k, wr_en, flag_we);
            end
            if (busy !== 1'b1) break;
            sp_load = 1'($urandom); sp_load_val = 16'($urandom); start = 1'($urandom);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; sp_load = 1'b0; start = 1'b0;

        model_sp = pop ? sp0 + 16'd2 : sp0 - 16'd2;
        total++;
        if (done_k != 3 + 2 * waits) begin
            bad++; $display("FAIL done_latency got=%0d want=%0d", done_k, 3 + 2 * waits);
        end
        total++;
        if (xfer != 2) begin
            bad++; $display("FAIL xfer_count got=%0d want=2", xfer);
        end
        total++;
        if (sp !== model_sp) begin
            bad++; $display("FAIL sp_after_op got=%h want=%h", sp, model_sp);
        end
    endtask

    task automatic load_sp(input logic [15:0] val, input bit with_start);
        sp_load = 1'b1; sp_load_val = val; start = with_start; op_pop = 1'b0;
        push_data = 16'hBEEF;
        @(posedge clk); #1;
        sp_load = 1'b0; start = 1'b0;
        model_sp = val;
        total++;
        if (sp !== val || busy !== 1'b0) begin
            bad++; $display("FAIL sp_load sp=%h busy=%b want sp=%h busy=0", sp, busy, val);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || sp !== val) begin
            bad++; $display("FAIL sp_load_idle busy=%b req=%b sp=%h want 0 0 %h", busy, mem_req, sp, val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_sp = 16'hFFFE;
        total++;
        if (sp !== 16'hFFFE) begin
            bad++; $display("FAIL reset_sp got=%h want=fffe", sp);
        end
        total++;
        if ({busy, done, fault, mem_req, mem_we, flag_we} !== 6'b0 || wr_en !== 2'd0) begin
            bad++; $display("FAIL reset_strobes got=%b wr_en=%0d want all 0",
                            {busy, done, fault, mem_req, mem_we, flag_we}, wr_en);
        end
        total++;
        if (mem_addr !== 16'h0 || mem_wdata !== 8'h0 || wr_reg !== 4'h0 ||
            wr_data !== 16'h0 || flag_data !== 8'h0) begin
            bad++; $display("FAIL reset_buses addr=%h wd=%h reg=%h wdat=%h fd=%h want 0",
                            mem_addr, mem_wdata, wr_reg, wr_data, flag_data);
        end
    endtask

    task automatic test_push_bc();
        do_op(1'b0, 1'b0, 4'd2, 16'h1234, 0);
        total++;
        if (tbmem[16'hFFFD] !== 8'h12 || tbmem[16'hFFFC] !== 8'h34 || sp !== 16'hFFFC) begin
            bad++; $display("FAIL push_bc mem fffd=%h fffc=%h sp=%h want 12 34 fffc",
                            tbmem[16'hFFFD], tbmem[16'hFFFC], sp);
        end
    endtask

    task automatic test_pop_de();
        do_op(1'b1, 1'b0, 4'd4, 16'h0000, 2);
        total++;
        if (sp !== 16'hFFFE) begin
            bad++; $display("FAIL pop_de_sp got=%h want=fffe", sp);
        end
    endtask

    task automatic test_pop_af();
        load_sp(16'hD000, 1'b0);
        tbmem[16'hD000] = 8'hFF;
        tbmem[16'hD001] = 8'h5A;
        do_op(1'b1, 1'b1, 4'd0, 16'h0000, 1);
    endtask

    task automatic test_sp_load_start();
        load_sp(16'h0001, 1'b1);
        do_op(1'b0, 1'b0, 4'd6, 16'hA55A, 0);
        total++;
        if (sp !== 16'hFFFF || tbmem[16'h0000] !== 8'hA5 || tbmem[16'hFFFF] !== 8'h5A) begin
            bad++; $display("FAIL push_wrap sp=%h m0000=%h mffff=%h want ffff a5 5a",
                            sp, tbmem[16'h0000], tbmem[16'hFFFF]);
        end
    endtask

    task automatic test_reset_mid();
        load_sp(16'hE000, 1'b0);
        start = 1'b1; op_pop = 1'b0; push_data = 16'h7788;
        @(posedge clk); #1;
        start = 1'b0;
        mem_ready = 1'b1;
        tbmem[16'hDFFF] = mem_wdata;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'hDFFE) begin
            bad++; $display("FAIL mid_push_lo req=%b addr=%h want 1 dffe", mem_req, mem_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_sp = 16'hFFFE;
        total++;
        if (mem_req !== 1'b0 || sp !== 16'hFFFE || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset req=%b sp=%h busy=%b want 0 fffe 0", mem_req, sp, busy);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (done !== 1'b0 || wr_en !== 2'd0) begin
                bad++; $display("FAIL mid_reset_no_done done=%b wr_en=%0d want 0 0", done, wr_en);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_guard();
        load_sp(16'hC001, 1'b0);
        do_op(1'b0, 1'b0, 4'd2, 16'h1111, 0);
        load_sp(16'hFFFE, 1'b0);
        do_op(1'b1, 1'b0, 4'd2, 16'h0000, 0);
        load_sp(16'hC002, 1'b0);
        do_op(1'b0, 1'b0, 4'd2, 16'h2222, 1);
    endtask

    task automatic test_back_to_back();
        load_sp(16'hF000, 1'b0);
        do_op(1'b0, 1'b0, 4'd2, 16'hCAFE, 0);
        do_op(1'b0, 1'b0, 4'd4, 16'hF00D, 0);
        do_op(1'b1, 1'b0, 4'd8, 16'h0000, 0);
        total++;
        if (wr_data !== 16'h0000 || sp !== 16'hEFFE) begin
            bad++; $display("FAIL b2b_idle wr_data=%h sp=%h want 0000 effe", wr_data, sp);
        end
        do_op(1'b1, 1'b0, 4'd2, 16'h0000, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) load_sp(16'($urandom), 1'($urandom));
            do_op(1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_pop = 1'b0; is_af = 1'b0; pair_idx = 4'd0;
        push_data = 16'h0; sp_load = 1'b0; sp_load_val = 16'h0;
        mem_rdata = 8'h0; mem_ready = 1'b0;
        for (int a = 0; a < 65536; a++) tbmem[a] = 8'($urandom);
        model_sp = 16'hFFFE;
        test_reset();
        test_push_bc();
        test_pop_de();
        test_pop_af();
        test_sp_load_start();
        test_reset_mid();
        test_guard();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
